// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: words pushed on a valid/ready
// handshake are serialised as start, data (LSB first), optional parity and
// one or two stop bits, each bit lasting Prescale+1 clocks.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    par_bit_q, par_bit_d;
    logic                    par_en_q, par_en_d;
    logic                    stop2_q, stop2_d;
    logic [PRESCALE_W-1:0]   pre_lat_q, pre_lat_d;
    logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    tx_d, busy_d;
    logic                    push_c, pop_c, start_c, bit_end_c;
    logic [DATA_WIDTH-1:0]   head_c;

    // Handshake: ready is a registered copy of "not full", independent of valid
    always_comb begin
        push_c    = Data_Valid & Data_Ready;
        head_c    = mem[rd_ptr_q];
        bit_end_c = (pre_cnt_q == pre_lat_q);
    end

    // Next-state and next-output logic of the frame sequencer
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        pre_lat_d = pre_lat_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = TX_OUT;
        busy_d    = busy;
        start_c   = 1'b0;
        pop_c     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (count_q != '0) begin
                    start_c = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                    pre_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    pre_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    pre_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    pre_cnt_d = '0;
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_W'(1);
                    end else if (count_q != '0) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start: pop the head word and freeze the line settings for this frame
        if (start_c) begin
            pop_c     = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            shreg_d   = head_c;
            par_bit_d = (^head_c) ^ PAR_TYP;
            par_en_d  = PAR_EN;
            stop2_d   = STOP2;
            pre_lat_d = Prescale;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
        end

        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // FIFO storage; pointers alone define its contents, so no reset needed
    always_ff @(posedge clk) begin
        if (rst && push_c) begin
            mem[wr_ptr_q] <= P_DATA;
        end
    end

    // State, counters, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            pre_lat_q  <= '0;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            Data_Ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            pre_lat_q  <= pre_lat_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            TX_OUT     <= tx_d;
            busy       <= busy_d;
            Data_Ready <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: fixed frame vectors, hand-written
// corner sequences, and random traffic against a line-schedule model.
module tb_uart_tx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pdata;
    logic          dv;
    logic          rdy;
    logic          pe, pt, s2;
    logic [PW-1:0] ps;
    logic          tx;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    // Reference model: queued words, and the per-clock line samples still to be shown
    logic [DW-1:0] mq[$];
    bit            lq[$];

    uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .P_DATA(pdata), .Data_Valid(dv), .Data_Ready(rdy),
        .PAR_EN(pe), .PAR_TYP(pt), .STOP2(s2), .Prescale(ps),
        .TX_OUT(tx), .busy(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one frame into line samples, each bit repeated Prescale+1 times
    function automatic void expand(input logic [DW-1:0] w, input bit pe_v, input bit pt_v,
                                   input bit s2_v, input int psv);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) b.push_back(w[i]);
        if (pe_v) b.push_back((^w) ^ pt_v);
        b.push_back(1'b1);
        if (s2_v) b.push_back(1'b1);
        foreach (b[k]) begin
            for (int r = 0; r <= psv; r++) lq.push_back(b[k]);
        end
    endfunction

    // One clock: inputs present at the edge feed the model, then outputs are compared
    task automatic tick();
        logic          c_rst, c_dv, c_pe, c_pt, c_s2;
        logic [DW-1:0] c_pd;
        logic [PW-1:0] c_ps;
        int            pre;
        c_rst = rst; c_dv = dv; c_pe = pe; c_pt = pt; c_s2 = s2; c_pd = pdata; c_ps = ps;
        @(posedge clk);
        #1;
        if (!c_rst) begin
            mq.delete();
            lq.delete();
        end else begin
            if (lq.size() > 0) void'(lq.pop_front());
            pre = mq.size();
            if (lq.size() == 0 && pre > 0) expand(mq.pop_front(), c_pe, c_pt, c_s2, int'(c_ps));
            if (c_dv && pre < int'(DEPTH)) mq.push_back(c_pd);
        end
        chk("model_tx", 32'(tx), 32'((lq.size() > 0) ? lq[0] : 1'b1));
        chk("model_busy", 32'(busy_o), 32'(lq.size() > 0));
        chk("model_ready", 32'(rdy), 32'(mq.size() < int'(DEPTH)));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        bit            pe, pt, s2;
        int            ps;
        string         seq;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int busy_cnt, busy_rises, guard, idx, accepted;
        bit saw_not_ready, prev_busy, acc;
        logic [DW-1:0] words[6];
        bit rec[50];

        vecs[0] = '{8'hCD, 1'b1, 1'b1, 1'b0, 0, "01011001101"};
        vecs[1] = '{8'hCD, 1'b1, 1'b0, 1'b0, 0, "01011001111"};
        vecs[2] = '{8'hCD, 1'b0, 1'b0, 1'b0, 0, "0101100111"};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 3, "01010010111"};

        rst = 1'b0; dv = 1'b0; pdata = '0; pe = 1'b0; pt = 1'b0; s2 = 1'b0; ps = '0;
        tick();
        tick();
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_ready", 32'(rdy), 32'd1);
        rst = 1'b1;
        tick();

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            pe = vecs[v].pe; pt = vecs[v].pt; s2 = vecs[v].s2; ps = PW'(vecs[v].ps);
            pdata = vecs[v].data; dv = 1'b1;
            tick();
            dv = 1'b0;
            chk($sformatf("v%0d_push_edge_tx", v), 32'(tx), 32'd1);
            chk($sformatf("v%0d_push_edge_busy", v), 32'(busy_o), 32'd0);
            busy_cnt = 0;
            for (int i = 0; i < vecs[v].seq.len(); i++) begin
                for (int j = 0; j <= vecs[v].ps; j++) begin
                    tick();
                    chk($sformatf("v%0d_bit%0d", v, i), 32'(tx), 32'(vecs[v].seq[i] == "1"));
                    if (busy_o) busy_cnt++;
                end
            end
            tick();
            chk($sformatf("v%0d_end_tx", v), 32'(tx), 32'd1);
            chk($sformatf("v%0d_end_busy", v), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_busy_clocks", v), 32'(busy_cnt),
                32'(vecs[v].seq.len() * (vecs[v].ps + 1)));
            tick();
        end

        // Back-to-back burst with valid held high through full
        pe = 1'b0; pt = 1'b0; s2 = 1'b0; ps = '0;
        for (int i = 0; i < 6; i++) words[i] = DW'(8'h11 * (i + 1));
        idx = 0; accepted = 0; guard = 0; busy_cnt = 0; busy_rises = 0;
        saw_not_ready = 1'b0; prev_busy = 1'b0;
        dv = 1'b1;
        while (accepted < 6 && guard < 300) begin
            pdata = words[idx];
            acc = (mq.size() < int'(DEPTH));
            tick();
            if (acc) begin idx++; accepted++; end
            if (!rdy) saw_not_ready = 1'b1;
            if (busy_o) busy_cnt++;
            if (busy_o && !prev_busy) busy_rises++;
            prev_busy = busy_o;
            guard++;
        end
        dv = 1'b0;
        chk("burst_all_accepted", 32'(accepted), 32'd6);
        guard = 0;
        while (busy_o && guard < 300) begin
            tick();
            if (busy_o) busy_cnt++;
            if (busy_o && !prev_busy) busy_rises++;
            prev_busy = busy_o;
            guard++;
        end
        chk("burst_drained", 32'(busy_o), 32'd0);
        chk("burst_saw_not_ready", 32'(saw_not_ready), 32'd1);
        chk("burst_busy_clocks", 32'(busy_cnt), 32'd60);
        chk("burst_busy_continuous", 32'(busy_rises), 32'd1);

        // Reset during data bit 3 with two words still queued
        for (int i = 0; i < 3; i++) begin
            pdata = DW'(8'h3C + i); dv = 1'b1;
            tick();
        end
        dv = 1'b0;
        tick(); tick(); tick();
        chk("abort_before_bit3", 32'(tx), 32'(1'b1));
        rst = 1'b0;
        tick();
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready", 32'(rdy), 32'd1);
        rst = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy_o || !tx) busy_cnt++;
        end
        chk("abort_no_resume", 32'(busy_cnt), 32'd0);

        // Settings changed mid-frame apply only to the next frame
        pe = 1'b1; pt = 1'b0; s2 = 1'b0; ps = PW'(1);
        pdata = 8'h3C; dv = 1'b1;
        tick();
        dv = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            rec[n] = tx;
            if (n == 3) begin pt = 1'b1; pdata = DW'($urandom); end
            if (n == 5) begin pdata = 8'h5A; dv = 1'b1; end
            if (n == 6) begin dv = 1'b0; pdata = DW'($urandom); end
        end
        chk("mid_f1_start", 32'(rec[0]), 32'd0);
        chk("mid_f1_bit2", 32'(rec[6]), 32'd1);
        chk("mid_f1_parity_even", 32'(rec[18]), 32'd0);
        chk("mid_f2_start", 32'(rec[22]), 32'd0);
        chk("mid_f2_bit1", 32'(rec[26]), 32'd1);
        chk("mid_f2_parity_odd", 32'(rec[40]), 32'd1);
        chk("mid_idle_after", 32'(rec[49]), 32'd1);

        // Random traffic, settings and occasional resets against the model
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 500; c++) begin
                rst   = ($urandom_range(0, 299) != 0);
                dv    = ($urandom_range(0, seg) == 0);
                pdata = DW'($urandom);
                pe    = 1'($urandom);
                pt    = 1'($urandom);
                s2    = 1'($urandom);
                ps    = PW'($urandom_range(0, 2));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of input words buffered (power of 2, legal 2..16).
REQ-003 The block SHALL have parameter PRESCALE_W, default 8, giving the width of the bit-period prescale input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port P_DATA, input, DATA_WIDTH bits: the word to transmit.
REQ-007 The block SHALL have port Data_Valid, input, 1 bit: P_DATA is offered for push.
REQ-008 The block SHALL have port Data_Ready, output, 1 bit: the FIFO can accept a word.
REQ-009 The block SHALL have port PAR_EN, input, 1 bit: 1 inserts a parity bit.
REQ-010 The block SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-011 The block SHALL have port STOP2, input, 1 bit: 1 sends two stop bits, 0 sends one.
REQ-012 The block SHALL have port Prescale, input, PRESCALE_W bits: each bit lasts Prescale+1 clocks.
REQ-013 The block SHALL have port TX_OUT, output, 1 bit: serial line, registered, idle high.
REQ-014 The block SHALL have port busy, output, 1 bit: a frame is on the line.

Function
REQ-015 A push SHALL occur on a rising edge where Data_Valid=1 and Data_Ready=1; when Data_Valid=1 and Data_Ready=0 the word SHALL be ignored and not queued.
REQ-016 Data_Ready SHALL equal NOT full, and SHALL be a function of FIFO occupancy only, with no combinational path from Data_Valid.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with the FIFO non-empty, the next edge SHALL pop the head word; that same edge SHALL latch PAR_EN, PAR_TYP, STOP2 and Prescale, enter START, drive TX_OUT=0 and drive busy=1.
REQ-019 A word pushed into an empty FIFO with the FSM in IDLE SHALL appear as a start bit on TX_OUT exactly 1 clock after the push edge.
REQ-020 The frame SHALL be sent in this order: start bit (0); data bits LSB first; parity bit if PAR_EN=1; 1 or 2 stop bits (1). Each bit SHALL be held for Prescale+1 clocks.
REQ-021 The parity bit SHALL be the XOR of all data bits for even parity, and its inverse for odd parity.
REQ-022 Changes on P_DATA, PAR_EN, PAR_TYP, STOP2 or Prescale during a frame SHALL NOT affect that frame; the new values SHALL apply from the next frame start.
REQ-023 At the end of the last stop bit with the FIFO non-empty, the FSM SHALL go directly to START with no idle bit between frames, and busy SHALL stay 1.
REQ-024 At the end of the last stop bit with the FIFO empty, the FSM SHALL go to IDLE with TX_OUT=1 and busy=0.
REQ-025 A push and a pop on the same edge SHALL leave the occupancy unchanged; pushes at full are excluded by REQ-016.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-027 Prescale=0 SHALL give 1 bit per clock.

Reset
REQ-028 While rst=0 at a rising edge, the block SHALL drive TX_OUT=1, busy=0 and Data_Ready=1, flush the FIFO, clear the bit and prescale counters, and place the FSM in IDLE.
REQ-029 A reset during a frame SHALL abort the frame; TX_OUT=1 SHALL be driven from the reset edge, and no partial frame SHALL resume after reset.

Verification
REQ-030 The bench SHALL check: Prescale=0, PAR_EN=1, PAR_TYP=1, P_DATA=8'b11001101 -> TX_OUT sequence 0,1,0,1,1,0,0,1,1,0,1, busy high for exactly 11 clocks.
REQ-031 The bench SHALL check: the same data with PAR_TYP=0 -> parity bit = 1; PAR_EN=0 -> 10-bit frame 0,1,0,1,1,0,0,1,1,1.
REQ-032 The bench SHALL check: Prescale=3, PAR_EN=0, STOP2=1, P_DATA=8'hA5 -> each bit held 4 clocks, 11 bits in total, busy high for 44 clocks, then TX_OUT=1 and busy=0.
REQ-033 The bench SHALL check: Prescale=0, Data_Valid held high with 6 distinct words -> Data_Ready drops once 4 words are queued; all accepted words are sent in order, back-to-back with no idle bit, and busy stays continuously high; the offered word is not lost while Data_Ready is low.
REQ-034 The bench SHALL check: rst=0 during data bit 3 of a frame with 2 words queued -> TX_OUT=1, busy=0 and Data_Ready=1 on the next edge, and no further frames are sent.
REQ-035 The bench SHALL check: PAR_TYP and P_DATA toggled mid-frame, then a second word pushed -> the first frame is unchanged, and the second frame uses the new PAR_TYP.
